// File: rtl/ysyx_25030081_ifu.sv
// ysyx_25030081_ifu: single-outstanding instruction fetch unit with redirect flush
module ysyx_25030081_ifu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_e;
  state_e state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, inst_pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic drop_q;
  logic unused_lsb;
  assign unused_lsb     = ^redirect_pc[1:0];
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT) && !redirect_valid && !rst;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  // Next PC: a redirect always wins, otherwise step past an instruction decode has taken
  always_comb
    pc_d = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00}
         : (inst_valid && inst_ready) ? pc_q + ADDR_WIDTH'(4) : pc_q;
  // Fetch FSM; drop marks an in-flight response that belongs to a superseded PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_REQ:
          if (imem_req_ready) begin
            state_q <= S_WAIT;
            drop_q  <= redirect_valid;
          end
        S_WAIT:
          if (imem_rsp_valid && (drop_q || redirect_valid)) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end else if (imem_rsp_valid) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc_q;
            state_q   <= S_OUT;
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        S_OUT:
          if (redirect_valid || inst_ready) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end
endmodule
